serial_adder_seq: RTL

//  Bit-serial N-bit adder sequencer: latches two operands, adds them LSB-first one bit per clock,

---
 rtl/serial_adder_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: captures two operands and a carry-in, then adds them LSB-first,
// one bit per clock, producing a serial sum stream plus the final parallel sum and carry-out.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             ser_sum_o,
  output logic             ser_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             sumBit;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  // One full-adder slice working on the current LSBs of the shift registers.
  assign sumBit  = aSh_q[0] ^ bSh_q[0] ^ carry_q;
  assign carry_d = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
  assign sum_d   = {sumBit, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            aSh_q   <= a_i;
            bSh_q   <= b_i;
            carry_q <= cin_i;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum_q[0].
          carry_q <= carry_d;
          sum_q   <= sum_d;
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_BIT) begin
            cout_q  <= carry_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ser_sum_o   = sumBit;
  assign ser_valid_o = (state_q == SHIFT);
  assign busy_o      = (state_q == SHIFT) || (state_q == DONE);
  assign done_o      = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

endmodule
